// File: rtl/pc_fetch_pkg.sv
// Shared types and default widths for the program-counter fetch block.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int PW_DEF = 10;
  localparam int CW_DEF = 16;

endpackage

// File: rtl/pc_fetch_if.sv
// Control and status bundle between the sequencer/decoder and the fetch unit.
interface pc_fetch_if #(
  parameter int PW = 10,
  parameter int CW = 16
);
  logic          start;
  logic          halt;
  logic          stall;
  logic          branch_abs;
  logic          branch_rel;
  logic [7:0]    target;
  logic [PW-1:0] prog_ctr;
  logic          fetch_valid;
  logic          done;
  logic [CW-1:0] instr_cnt;
  logic          br_conflict;

  modport master (
    output start, halt, stall, branch_abs, branch_rel, target,
    input  prog_ctr, fetch_valid, done, instr_cnt, br_conflict
  );

  modport slave (
    input  start, halt, stall, branch_abs, branch_rel, target,
    output prog_ctr, fetch_valid, done, instr_cnt, br_conflict
  );
endinterface

// File: rtl/pc_next.sv
// Combinational next-PC selection: hold, absolute jump, relative jump or increment.
module pc_next #(
  parameter int PW = 10
) (
  input  logic [PW-1:0] pc,
  input  logic [7:0]    target,
  input  logic          hold,
  input  logic          branch_abs,
  input  logic          branch_rel,
  output logic [PW-1:0] pc_nxt
);

  logic [PW-1:0] target_zx;
  logic [PW-1:0] target_sx;

  assign target_zx = {{(PW-8){1'b0}}, target};
  assign target_sx = {{(PW-8){target[7]}}, target};

  always_comb begin
    pc_nxt = pc + PW'(1);
    if (hold) begin
      pc_nxt = pc;
    end else if (branch_abs) begin
      pc_nxt = target_zx;
    end else if (branch_rel) begin
      pc_nxt = pc + target_sx;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch sequencer: IDLE/RUN/HALT control of the program counter, retired
// instruction count and sticky branch-conflict flag.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  pc_fetch_if.slave   bus
);

  fetch_state_e  state, state_nxt;
  logic [PW-1:0] prog_ctr, prog_ctr_d, pc_cand;
  logic [CW-1:0] instr_cnt, instr_cnt_d;
  logic          br_conflict, br_conflict_d;

  pc_next #(.PW(PW)) u_pc_next (
    .pc         (prog_ctr),
    .target     (bus.target),
    .hold       (bus.halt | bus.stall),
    .branch_abs (bus.branch_abs),
    .branch_rel (bus.branch_rel),
    .pc_nxt     (pc_cand)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      prog_ctr    <= '0;
      instr_cnt   <= '0;
      br_conflict <= 1'b0;
    end else begin
      state       <= state_nxt;
      prog_ctr    <= prog_ctr_d;
      instr_cnt   <= instr_cnt_d;
      br_conflict <= br_conflict_d;
    end
  end

  always_comb begin
    state_nxt     = state;
    prog_ctr_d    = prog_ctr;
    instr_cnt_d   = instr_cnt;
    br_conflict_d = br_conflict;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          state_nxt     = ST_RUN;
          prog_ctr_d    = '0;
          instr_cnt_d   = '0;
          br_conflict_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.halt) begin
          state_nxt = ST_HALT;
        end else if (!bus.stall) begin
          prog_ctr_d = pc_cand;
          // Count saturates rather than wrapping so long programs read as "many".
          if (instr_cnt != '1) begin
            instr_cnt_d = instr_cnt + CW'(1);
          end
          if (bus.branch_abs && bus.branch_rel) begin
            br_conflict_d = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.prog_ctr    = prog_ctr;
  assign bus.instr_cnt   = instr_cnt;
  assign bus.br_conflict = br_conflict;
  assign bus.fetch_valid = (state == ST_RUN);
  assign bus.done        = (state == ST_HALT);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; a second narrow-counter instance
// shadows the same stimulus to exercise instruction-count saturation.
module tb_pc_fetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pc_fetch_if #(.PW(10), .CW(16)) b ();
  pc_fetch_if #(.PW(10), .CW(3))  b2 ();

  pc_fetch #(.PW(10), .CW(16)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  pc_fetch #(.PW(10), .CW(3))  dut_sat (.clk(clk), .rst(rst), .bus(b2.slave));

  assign b2.start      = b.start;
  assign b2.halt       = b.halt;
  assign b2.stall      = b.stall;
  assign b2.branch_abs = b.branch_abs;
  assign b2.branch_rel = b.branch_rel;
  assign b2.target     = b.target;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic abs, input logic rel, input logic stl,
                       input logic hlt, input logic [7:0] tgt);
    b.branch_abs = abs;
    b.branch_rel = rel;
    b.stall      = stl;
    b.halt       = hlt;
    b.target     = tgt;
    step();
    b.branch_abs = 1'b0;
    b.branch_rel = 1'b0;
    b.stall      = 1'b0;
    b.halt       = 1'b0;
    b.target     = 8'h00;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".pc"},   32'(b.prog_ctr), 32'd0);
    check({tag, ".cnt"},  32'(b.instr_cnt), 32'd0);
    check({tag, ".conf"}, 32'(b.br_conflict), 32'd0);
    check({tag, ".fv"},   32'(b.fetch_valid), 32'd0);
    check({tag, ".done"}, 32'(b.done), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    b.start      = 1'b0;
    b.halt       = 1'b0;
    b.stall      = 1'b0;
    b.branch_abs = 1'b0;
    b.branch_rel = 1'b0;
    b.target     = 8'h00;

    #12;
    check_zero("reset");

    // Start while reset is held must be ignored
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    check("start_in_reset.fv", 32'(b.fetch_valid), 32'd0);
    rst = 1'b0;
    step();
    step();
    check_zero("idle");

    // Start and five plain increments; a stray start at pc=2 is ignored
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    check("run0.pc", 32'(b.prog_ctr), 32'd0);
    check("run0.fv", 32'(b.fetch_valid), 32'd1);
    check("run0.cnt", 32'(b.instr_cnt), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) b.start = 1'b1;
      step();
      b.start = 1'b0;
      check($sformatf("inc.pc%0d", i), 32'(b.prog_ctr), 32'(i));
    end
    check("inc.cnt", 32'(b.instr_cnt), 32'd5);
    check("inc.fv", 32'(b.fetch_valid), 32'd1);
    check("sat.cnt5", 32'(b2.instr_cnt), 32'd5);

    repeat (5) step();
    check("pc10", 32'(b.prog_ctr), 32'd10);
    check("sat.cnt7", 32'(b2.instr_cnt), 32'd7);

    drive(1, 0, 0, 0, 8'h5E);
    check("abs.pc", 32'(b.prog_ctr), 32'd94);
    drive(0, 1, 0, 0, 8'hFE);
    check("rel_neg.pc", 32'(b.prog_ctr), 32'd92);
    check("rel.cnt", 32'(b.instr_cnt), 32'd12);

    drive(0, 1, 0, 0, 8'h80);
    check("rel_m128.pc", 32'(b.prog_ctr), 32'd988);
    drive(0, 1, 0, 0, 8'h23);
    check("rel_pos.pc", 32'(b.prog_ctr), 32'd1023);
    step();
    check("wrap.pc", 32'(b.prog_ctr), 32'd0);
    step();
    step();
    check("pc2", 32'(b.prog_ctr), 32'd2);
    drive(0, 1, 0, 0, 8'hF0);
    check("rel_wrap.pc", 32'(b.prog_ctr), 32'd1010);
    check("wrap.cnt", 32'(b.instr_cnt), 32'd18);

    drive(1, 0, 0, 0, 8'd7);
    check("pc7", 32'(b.prog_ctr), 32'd7);
    drive(1, 1, 1, 0, 8'd99);
    check("stall.pc", 32'(b.prog_ctr), 32'd7);
    check("stall.cnt", 32'(b.instr_cnt), 32'd19);
    check("stall.conf", 32'(b.br_conflict), 32'd0);
    drive(1, 1, 0, 0, 8'd30);
    check("conf.pc", 32'(b.prog_ctr), 32'd30);
    check("conf.flag", 32'(b.br_conflict), 32'd1);
    check("conf.cnt", 32'(b.instr_cnt), 32'd20);
    step();
    check("conf.sticky", 32'(b.br_conflict), 32'd1);

    drive(1, 0, 0, 0, 8'd40);
    check("pc40", 32'(b.prog_ctr), 32'd40);
    drive(1, 0, 0, 1, 8'd77);
    check("halt.done", 32'(b.done), 32'd1);
    check("halt.fv", 32'(b.fetch_valid), 32'd0);
    check("halt.cnt", 32'(b.instr_cnt), 32'd22);
    for (int i = 0; i < 10; i++) begin
      drive(i[0], ~i[0], 1'b0, 1'b0, 8'd5);
      check($sformatf("halt_hold.pc%0d", i), 32'(b.prog_ctr), 32'd40);
    end
    check("halt_hold.done", 32'(b.done), 32'd1);
    check("halt_hold.cnt", 32'(b.instr_cnt), 32'd22);
    check("halt_hold.conf", 32'(b.br_conflict), 32'd1);

    b.start = 1'b1;
    step();
    b.start = 1'b0;
    check("restart.pc", 32'(b.prog_ctr), 32'd0);
    check("restart.cnt", 32'(b.instr_cnt), 32'd0);
    check("restart.conf", 32'(b.br_conflict), 32'd0);
    check("restart.fv", 32'(b.fetch_valid), 32'd1);
    check("restart.done", 32'(b.done), 32'd0);

    drive(1, 0, 0, 0, 8'd65);
    check("pc65", 32'(b.prog_ctr), 32'd65);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    #3;
    rst = 1'b0;
    step();
    step();
    check_zero("post_rst");

    b.start = 1'b1;
    step();
    b.start = 1'b0;
    step();
    check("rerun.pc", 32'(b.prog_ctr), 32'd1);
    check("rerun.fv", 32'(b.fetch_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter PW, default 10: program-counter width in bits.
REQ-002 Parameter CW, default 16: retired-instruction counter width in bits.
REQ-003 Clk  input  1: sole clock; all state updates on rising edge.
REQ-004 Reset  input  1: asynchronous, active-high reset.
REQ-005 Start  input  1: one-cycle pulse; begins program execution from address 0.
REQ-006 Halt  input  1: decoder has issued the done instruction; stop fetching.
REQ-007 Stall  input  1: hold the current PC this cycle.
REQ-008 BranchAbs  input  1: take an absolute jump to Target.
REQ-009 BranchRel  input  1: take a relative jump by signed Target.
REQ-010 Target  input  8: jump operand from the branch-target lookup table.
REQ-011 ProgCtr  output  PW: current instruction address to instruction memory.
REQ-012 FetchValid  output  1: ProgCtr is a live fetch address (state RUN).
REQ-013 Done  output  1: program finished (state HALT).
REQ-014 InstrCnt  output  CW: instructions retired since last Start.
REQ-015 BrConflict  output  1: sticky flag; BranchAbs and BranchRel were seen together.

Function
REQ-016 FSM states: IDLE, RUN, HALT; registered state.
REQ-017 IDLE: Start -> RUN with ProgCtr=0, InstrCnt=0, BrConflict=0; all other inputs ignored.
REQ-018 RUN: Halt -> HALT on the next edge; ProgCtr and InstrCnt then freeze.
REQ-019 HALT: Start -> RUN with ProgCtr=0, InstrCnt=0, BrConflict=0; otherwise all values hold.
REQ-020 Start in RUN is ignored.
REQ-021 RUN next-PC priority, highest first: Halt (hold), Stall (hold), BranchAbs, BranchRel, increment.
REQ-022 BranchAbs: ProgCtr <= zero-extend(Target) to PW bits.
REQ-023 BranchRel: ProgCtr <= ProgCtr + sign-extend(Target); result taken modulo 2^PW.
REQ-024 Increment: ProgCtr <= ProgCtr + 1 modulo 2^PW; the maximum address wraps to 0.
REQ-025 Branch inputs are ignored when Stall or Halt is high.
REQ-026 InstrCnt increments once per RUN cycle with Halt=0 and Stall=0.
REQ-027 InstrCnt saturates at 2^CW-1 and does not wrap.
REQ-028 BrConflict sets when BranchAbs and BranchRel are both high in an unstalled RUN cycle (absolute wins); it clears only on Start or Reset.
REQ-029 FetchValid = (state==RUN); Done = (state==HALT); both are decoded from registered state, no combinational input paths.
REQ-030 Latency: a branch asserted in cycle N appears on ProgCtr in cycle N+1; there are no delay slots.

Reset
REQ-031 Reset asserted at any time immediately forces state IDLE, ProgCtr=0, InstrCnt=0, BrConflict=0, FetchValid=0, Done=0.
REQ-032 Reset during RUN abandons the program; restart requires a new Start after deassertion.
REQ-033 Start coincident with Reset is ignored.

Structure
REQ-034 A shared package holds the fetch-state enum (IDLE/RUN/HALT) and default PW/CW constants.
REQ-035 One combinational sub-module, pc_next, computes the next PC from ProgCtr, Target and the branch controls.
REQ-036 Target is consumed combinationally from the lookup table in the same cycle; there is no extra register on it.

Verification
REQ-037 Reset, Start, 5 idle cycles -> ProgCtr 0,1,2,3,4,5; InstrCnt=5; FetchValid=1.
REQ-038 ProgCtr=10, BranchAbs with Target=8'h5E -> next ProgCtr=94; BranchRel with Target=8'hFE at ProgCtr=94 -> 92.
REQ-039 ProgCtr=1023, increment -> 0; ProgCtr=2, BranchRel Target=8'hF0 -> 1010.
REQ-040 Stall plus BranchAbs at ProgCtr=7 -> ProgCtr stays 7 and InstrCnt unchanged; BranchAbs plus BranchRel (Target=30) -> ProgCtr=30 and BrConflict=1.
REQ-041 Halt at ProgCtr=40 -> Done=1, ProgCtr=40 held for 10 cycles; then Start -> RUN, ProgCtr=0, InstrCnt=0, BrConflict=0.
REQ-042 Reset pulse mid-RUN at ProgCtr=65, asynchronous to Clk -> outputs zero immediately; state IDLE until the next Start.
